// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared memory port between instruction fetch and load/store,
// one serialized fixed-latency access at a time. Define ARB_ROUND_ROBIN_EN for round-robin grants.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_ack,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wmask,
    output logic                d_ack,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);
    localparam int MW = DATA_W / 8;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              gnt_q, gnt_d;          // 1 = data requester, 0 = fetch
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [MW-1:0]     mem_wmask_q, mem_wmask_d;
    logic [DATA_W-1:0] rdata_q [2];           // index 0 = fetch, 1 = data
    logic [DATA_W-1:0] rdata_d [2];
    logic [1:0]        ack_vec;
    logic              take_d;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant_q, last_grant_d;
    // On a tie the requester that did not win last time is chosen.
    always_comb begin
        take_d = d_req;
        if (d_req && i_req) begin
            take_d = ~last_grant_q;
        end
    end
`else
    always_comb begin
        take_d = d_req;
    end
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gnt_d       = gnt_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wmask_d = mem_wmask_q;
        for (int k = 0; k < 2; k++) begin
            rdata_d[k] = rdata_q[k];
        end
`ifdef ARB_ROUND_ROBIN_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (d_req || i_req) begin
                    gnt_d       = take_d;
                    mem_addr_d  = take_d ? d_addr : i_addr;
                    mem_we_d    = take_d && d_we;
                    mem_wmask_d = (take_d && d_we) ? d_wmask : '0;
                    if (take_d) begin
                        mem_wdata_d = d_wdata;
                    end
`ifdef ARB_ROUND_ROBIN_EN
                    last_grant_d = take_d;
`endif
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (mem_we_q) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d   = 3'(MEM_LAT);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    rdata_d[gnt_q] = mem_rdata;
                    state_d        = S_RESP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            gnt_q       <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wmask_q <= '0;
            rdata_q[0]  <= '0;
            rdata_q[1]  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wmask_q <= mem_wmask_d;
            rdata_q[0]  <= rdata_d[0];
            rdata_q[1]  <= rdata_d[1];
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ack
            assign ack_vec[gi] = (state_q == S_RESP) && (gnt_q == 1'(gi));
        end
    endgenerate

    assign i_ack     = ack_vec[0];
    assign d_ack     = ack_vec[1];
    assign i_rdata   = rdata_q[0];
    assign d_rdata   = rdata_q[1];
    assign mem_en    = (state_q == S_ISSUE);
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wmask = mem_wmask_q;
    assign busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed accesses push expected memory
// strobes and acks; a negedge monitor pops and compares them.
module tb_mem_port_arbiter;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [3:0]  d_wmask;
    logic        i_ack, d_ack, mem_en, mem_we, busy;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } mem_exp_t;

    typedef struct {
        int          cyc;
        logic        is_d;
        logic        we;
        logic [31:0] rdata;
    } ack_exp_t;

    mem_exp_t mq[$];
    ack_exp_t aq[$];
    logic [31:0] hold_i = 32'h0;
    logic [31:0] hold_d = 32'h0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wmask(d_wmask), .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: read data appears exactly LAT cycles after the strobe, junk otherwise.
    function automatic logic [31:0] mem_val(input logic [31:0] a);
        case (a)
            32'h0000_0100: mem_val = 32'h0050_0093;
            32'h0000_0104: mem_val = 32'h00A0_0113;
            32'h0000_2004: mem_val = 32'hCAFE_F00D;
            default:       mem_val = 32'h1357_9BDF;
        endcase
    endfunction

    logic [31:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= (mem_en && !mem_we) ? mem_val(mem_addr) : 32'hEEEE_EEEE;
        for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign mem_rdata = pipe[LAT-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_acc(input int t, input logic is_d, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] wmask,
                            input logic [31:0] rdata, input logic want_ack);
        mq.push_back('{cyc: t + 1, addr: addr, we: we, wdata: wdata, wmask: wmask});
        if (want_ack)
            aq.push_back('{cyc: t + 2 + (we ? 0 : LAT), is_d: is_d, we: we, rdata: rdata});
    endtask

    // Monitor
    always @(negedge clk) begin
        if (cyc > 0) begin
            if (mem_en) begin
                if (mq.size() == 0) begin
                    chk("unexpected_mem_en_addr", mem_addr, 32'hFFFF_FFFF);
                end else begin
                    mem_exp_t m;
                    m = mq.pop_front();
                    chk("mem_en_cycle", cyc, m.cyc);
                    chk("mem_addr", mem_addr, m.addr);
                    chk("mem_we", {31'b0, mem_we}, {31'b0, m.we});
                    chk("mem_wmask", {28'b0, mem_wmask}, {28'b0, m.wmask});
                    if (m.we) chk("mem_wdata", mem_wdata, m.wdata);
                    chk("busy_in_issue", {31'b0, busy}, 32'd1);
                end
            end
            if (i_ack || d_ack) begin
                if (aq.size() == 0 || (i_ack && d_ack)) begin
                    chk("unexpected_ack_id", {30'b0, d_ack, i_ack}, 32'd0);
                end else begin
                    ack_exp_t a;
                    a = aq.pop_front();
                    chk("ack_cycle", cyc, a.cyc);
                    chk("ack_is_d", {31'b0, d_ack}, {31'b0, a.is_d});
                    if (!a.we) begin
                        if (a.is_d) begin
                            chk("d_rdata", d_rdata, a.rdata);
                            hold_d = a.rdata;
                        end else begin
                            chk("i_rdata", i_rdata, a.rdata);
                            hold_i = a.rdata;
                        end
                    end
                end
            end else if (rst_n) begin
                chk("i_rdata_hold", i_rdata, hold_i);
                chk("d_rdata_hold", d_rdata, hold_d);
            end
        end
    end

    task automatic wait_ack(input logic is_d);
        int n;
        for (n = 0; n < 40; n++) begin
            @(negedge clk);
            if (is_d ? d_ack : i_ack) break;
        end
        if (n == 40) chk(is_d ? "d_ack_timeout" : "i_ack_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        int t;
        rst_n = 1'b0; i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
        i_addr = 32'h104; d_addr = 32'h2004; d_wdata = 32'h0; d_wmask = 4'h0;

        // Reset held two cycles with both requests asserted
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("rst_i_ack", {31'b0, i_ack}, 32'd0);
            chk("rst_d_ack", {31'b0, d_ack}, 32'd0);
            chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
            chk("rst_busy", {31'b0, busy}, 32'd0);
            chk("rst_mem_addr", mem_addr, 32'd0);
            chk("rst_mem_wmask", {28'b0, mem_wmask}, 32'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        push_acc(cyc, 1'b1, 1'b0, 32'h2004, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b1);
        wait_ack(1'b1);
        d_req = 1'b0; i_req = 1'b0;
        step(1);

        // Lone fetch
        i_addr = 32'h100; i_req = 1'b1;
        push_acc(cyc, 1'b0, 1'b0, 32'h100, 32'h0, 4'h0, 32'h0050_0093, 1'b1);
        wait_ack(1'b0);
        i_req = 1'b0;
        step(3);

        // Store
        d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF; d_wmask = 4'b0011; d_req = 1'b1;
        push_acc(cyc, 1'b1, 1'b1, 32'h2000, 32'hDEAD_BEEF, 4'b0011, 32'h0, 1'b1);
        wait_ack(1'b1);
        d_req = 1'b0; d_we = 1'b0;
        step(2);

        // Simultaneous reads: D first, I one access later
        d_addr = 32'h2004; i_addr = 32'h104; d_req = 1'b1; i_req = 1'b1;
        t = cyc;
        push_acc(t, 1'b1, 1'b0, 32'h2004, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b1);
        push_acc(t + LAT + 3, 1'b0, 1'b0, 32'h104, 32'h0, 4'h0, 32'h00A0_0113, 1'b1);
        fork
            begin wait_ack(1'b1); d_req = 1'b0; end
            begin wait_ack(1'b0); i_req = 1'b0; end
        join
        step(2);

        // Reset during WAIT of a data load: no ack may follow
        d_addr = 32'h2008; d_req = 1'b1;
        push_acc(cyc, 1'b1, 1'b0, 32'h2008, 32'h0, 4'h0, 32'h0, 1'b0);
        step(2);
        rst_n = 1'b0; d_req = 1'b0; hold_i = 32'h0; hold_d = 32'h0;
        step(1);
        rst_n = 1'b1;
        step(1);
        i_addr = 32'h104; i_req = 1'b1;
        push_acc(cyc, 1'b0, 1'b0, 32'h104, 32'h0, 4'h0, 32'h00A0_0113, 1'b1);
        wait_ack(1'b0);
        i_req = 1'b0;
        step(2);

        // Both requests held through four accesses
        d_addr = 32'h2004; i_addr = 32'h100; d_req = 1'b1; i_req = 1'b1;
        t = cyc;
        for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
            if (k % 2 == 0)
                push_acc(t + k * (LAT + 3), 1'b1, 1'b0, 32'h2004, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b1);
            else
                push_acc(t + k * (LAT + 3), 1'b0, 1'b0, 32'h100, 32'h0, 4'h0, 32'h0050_0093, 1'b1);
`else
            push_acc(t + k * (LAT + 3), 1'b1, 1'b0, 32'h2004, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b1);
`endif
        end
        step(4 * (LAT + 3));
        d_req = 1'b0; i_req = 1'b0;
        step(8);

        @(negedge clk);
        chk("final_busy", {31'b0, busy}, 32'd0);
        chk("mem_queue_left", mq.size(), 32'd0);
        chk("ack_queue_left", aq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single unified memory port of the multicycle RISC-V core between two requesters: the instruction-fetch path (read-only) and the load/store path (read/write).
- Sits between the control/datapath and the memory array.
- Turns the control unit's fetch and memory-state requests into one serialized, fixed-latency memory access each, with a req/ack handshake per requester.
- Grants by fixed priority (data over fetch), or round-robin when the optional feature is compiled in.

Parameters:
ADDR_W, 32, address width of all address ports
DATA_W, 32, data width; mask width is DATA_W/8
MEM_LAT, 1, memory read latency in cycles after the mem_en cycle; legal range 1..7

Ports:
clk  input  1  system clock, all logic on posedge
rst_n  input  1  synchronous active-low reset
i_req  input  1  fetch request, held until i_ack
i_addr  input  ADDR_W  fetch address
i_ack  output  1  one-cycle pulse, fetch complete
i_rdata  output  DATA_W  fetched instruction, valid with i_ack and held until the next fetch completes
d_req  input  1  data request, held until d_ack
d_we  input  1  1 = store, 0 = load
d_addr  input  ADDR_W  data address
d_wdata  input  DATA_W  store data
d_wmask  input  DATA_W/8  store byte enables
d_ack  output  1  one-cycle pulse, data access complete
d_rdata  output  DATA_W  load data, valid with d_ack and held until the next load completes
mem_en  output  1  memory access strobe, high exactly one cycle per access
mem_we  output  1  write enable, qualified by mem_en
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_wmask  output  DATA_W/8  byte enables; 0 on reads
mem_rdata  input  DATA_W  read data, valid MEM_LAT cycles after the mem_en cycle
busy  output  1  high whenever the state is not IDLE

Behaviour:
- Reset (rst_n low at a posedge):
  - State goes to IDLE and the wait counter clears.
  - mem_en, mem_we, i_ack, d_ack and busy go to 0.
  - mem_addr, mem_wdata, mem_wmask, i_rdata and d_rdata go to 0.
  - Reset wins over every other event.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE (cycle T):
  - d_req=1: grant D. Otherwise i_req=1: grant I. Otherwise stay in IDLE.
  - On grant, register address, we, wdata and mask (mask forced to 0 for reads and for I) and go to ISSUE.
- ISSUE (T+1):
  - mem_en=1 and mem_we = granted we; mem_* outputs come from registers only.
  - Write: go to RESP. Read: go to WAIT with counter = MEM_LAT.
- WAIT (T+2 .. T+1+MEM_LAT):
  - Counter decrements each cycle.
  - In the last WAIT cycle, mem_rdata is captured into the granted requester's rdata register, then go to RESP.
- RESP: pulse the granted requester's ack for one cycle, then go to IDLE.
  - Requests are not sampled in RESP, so a stale req is never re-granted.
- Latency from req to ack, requester idle on entry:
  - Write: 2 cycles (ack at T+2).
  - Read: MEM_LAT+2 cycles (ack at T+2+MEM_LAT).
  - Back-to-back accesses cost one extra IDLE cycle.
- mem_addr, mem_wdata, mem_we and mem_wmask hold their last values outside ISSUE; only mem_en qualifies them.
- The non-granted requester's ack stays 0 and its rdata is unchanged.
- Protocol violation: if req drops before ack, the transaction still completes and ack still pulses. Request inputs are sampled only in IDLE.
- Fixed priority may starve I under continuous d_req. This is acceptable: the core issues at most one data access per instruction.
- Reset during ISSUE/WAIT/RESP: the in-flight access is abandoned, no ack is produced, and the next request after release is served normally.

Optional Feature:
Macro ARB_ROUND_ROBIN_EN.
- Defined: a last_grant bit, reset to I so that D wins the first tie.
  - When both requests are high in IDLE, the requester not granted last wins.
  - A lone request is always granted.
  - last_grant updates on every grant.
- Undefined: fixed priority, D over I, and no last_grant register exists.

Test Plan:
- Reset: rst_n=0 for 2 cycles with i_req=d_req=1 -> i_ack=d_ack=0, mem_en=0, busy=0 throughout; the first grant occurs in the first cycle after release (D).
- Lone fetch, MEM_LAT=2:
  - Stimulus: i_req at T with i_addr=0x100; memory drives mem_rdata=0x00500093 at T+3.
  - Response: mem_en=1, mem_we=0, mem_addr=0x100 at T+1 only; i_ack=1 at T+4 with i_rdata=0x00500093; i_rdata held after the ack.
- Store:
  - Stimulus: d_req, d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF, d_wmask=4'b0011.
  - Response: mem_en=mem_we=1, mem_wmask=0011 at T+1; d_ack at T+2; i_ack stays 0.
- Simultaneous, MEM_LAT=1, both reads (d_addr=0x2004, i_addr=0x104):
  - D: mem_en at T+1, d_ack at T+3.
  - I: granted at T+4, mem_en at T+5 with mem_addr=0x104, i_ack at T+7.
- Reset mid-read: rst_n=0 in a WAIT cycle of a D load -> d_ack never pulses for it; a new i_req after release completes with nominal MEM_LAT+2 latency.
- ARB_ROUND_ROBIN_EN defined, both reqs held high continuously (re-asserted after each ack) -> grant order D, I, D, I; without the macro -> D, D, D, D.
